// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, memory and status signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              p0_req, p0_we, p0_ack, p0_rsp_valid, p0_err;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_ack, p1_rsp_valid, p1_err;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic              mem_write, mem_read, busy;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_read_data,
    input  p0_ack, p0_rsp_valid, p0_err, p0_rdata, p1_ack, p1_rsp_valid, p1_err, p1_rdata,
    input  mem_access_addr, mem_write_data, mem_write, mem_read, busy
  );
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_read_data,
    output p0_ack, p0_rsp_valid, p0_err, p0_rdata, p1_ack, p1_rsp_valid, p1_err, p1_rdata,
    output mem_access_addr, mem_write_data, mem_write, mem_read, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the 8-entry data memory (DMEM_ARB_FIXED_PRIO_EN: port 0 always wins)
module dmem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state, state_n;
  logic              we_q, owner, last_grant, sel, grant, oor, acc, resp;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign sel = !bus.p0_req;
`else
  assign sel = (bus.p0_req && bus.p1_req) ? !last_grant : bus.p1_req;
`endif

  assign grant = (state == IDLE) && (bus.p0_req || bus.p1_req);
  assign acc   = state == ACCESS;
  assign resp  = state == RESP;
  assign oor   = |addr_q[ADDR_W-1:DEPTH_LOG2];

  // state register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // next state and all strobes decoded from state, so memory strobes exist only in ACCESS
  always_comb begin
    state_n             = grant ? ACCESS : acc ? RESP : IDLE;
    bus.p0_ack          = grant && !sel;
    bus.p1_ack          = grant && sel;
    bus.p0_rsp_valid    = resp && !owner;
    bus.p1_rsp_valid    = resp && owner;
    bus.p0_err          = resp && !owner && oor;
    bus.p1_err          = resp && owner && oor;
    bus.mem_access_addr = acc ? addr_q : '0;
    bus.mem_write_data  = acc ? wdata_q : '0;
    bus.mem_write       = acc && we_q && !oor;
    bus.mem_read        = acc && !we_q && !oor;
    bus.busy            = state != IDLE;
  end

  // latch the granted request and capture read data at the end of ACCESS
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q         <= 1'b0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
    end else begin
      if (grant) begin
        we_q       <= sel ? bus.p1_we : bus.p0_we;
        addr_q     <= sel ? bus.p1_addr : bus.p0_addr;
        wdata_q    <= sel ? bus.p1_wdata : bus.p0_wdata;
        owner      <= sel;
        last_grant <= sel;
      end
      if (acc && !we_q && owner) bus.p1_rdata <= oor ? '0 : bus.mem_read_data;
      if (acc && !we_q && !owner) bus.p0_rdata <= oor ? '0 : bus.mem_read_data;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;
  typedef struct packed {logic port; logic we; logic [15:0] addr; logic [15:0] wdata;} ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem [8];
  logic [15:0] mdl [8];
  logic [15:0] rd_exp [2];
  ent_t        exp_q [$];
  logic        grants [$];
  int          ack_cnt [2];
  int          rsp_cnt [2];
  int          strobes = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always @(posedge clk) if (bus.mem_write) mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data;
  assign bus.mem_read_data = mem[bus.mem_access_addr[2:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    ent_t e;
    logic err;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        rd_exp[0] = '0;
        rd_exp[1] = '0;
      end else begin
        if (bus.mem_write || bus.mem_read) strobes++;
        if (bus.p0_ack || bus.p1_ack) begin
          e.port  = bus.p1_ack;
          e.we    = bus.p1_ack ? bus.p1_we : bus.p0_we;
          e.addr  = bus.p1_ack ? bus.p1_addr : bus.p0_addr;
          e.wdata = bus.p1_ack ? bus.p1_wdata : bus.p0_wdata;
          exp_q.push_back(e);
          grants.push_back(bus.p1_ack);
          ack_cnt[bus.p1_ack]++;
        end
        if (bus.p0_rsp_valid || bus.p1_rsp_valid) begin
          rsp_cnt[bus.p1_rsp_valid]++;
          if (exp_q.size() == 0) chk("rsp_spurious", {bus.p1_rsp_valid, bus.p0_rsp_valid}, 2'b00);
          else begin
            e = exp_q.pop_front();
            err = e.addr[15:3] != 0;
            if (!e.we) rd_exp[e.port] = err ? 16'h0 : mdl[e.addr[2:0]];
            else if (!err) mdl[e.addr[2:0]] = e.wdata;
            chk("rsp_port", {bus.p1_rsp_valid, bus.p0_rsp_valid}, (e.port ? 2'b10 : 2'b01));
            chk("rsp_err", (e.port ? bus.p1_err : bus.p0_err), err);
            chk("rsp_rdata", (e.port ? bus.p1_rdata : bus.p0_rdata), rd_exp[e.port]);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  task automatic op(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int c = 0;
    drive(port, 1'b1, we, addr, wdata);
    #1;
    while (!(port ? bus.p1_ack : bus.p0_ack) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("op_ack", (port ? bus.p1_ack : bus.p0_ack), 1'b1);
    @(posedge clk); #1;
    drive(port, 1'b0, we, addr, wdata);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (bus.busy && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic run_both(input int n);
    int got = 0;
    int cyc = 0;
    bus.p0_req = 1'b1;
    bus.p1_req = 1'b1;
    #1;
    while (got < n && cyc < 100) begin
      if (bus.p0_ack || bus.p1_ack) got++;
      if (got < n) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(posedge clk); #1;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    chk("both_grants", got, n);
    wait_idle();
  endtask

  initial begin
    int s;
    int a1, r1;
    logic exp_g [4];
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_p0_rdata", bus.p0_rdata, 16'h0);
    chk("rst_p1_rdata", bus.p1_rdata, 16'h0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_p0_err", bus.p0_err, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'h3, 16'hA5A5);
    #1;
    chk("wr_ack", bus.p0_ack, 1'b1);
    chk("wr_no_early_write", bus.mem_write, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h3, 16'hA5A5);
    chk("wr_mem_write", bus.mem_write, 1'b1);
    chk("wr_mem_addr", bus.mem_access_addr, 16'h3);
    chk("wr_mem_data", bus.mem_write_data, 16'hA5A5);
    @(posedge clk); #1;
    chk("wr_rsp_valid", bus.p0_rsp_valid, 1'b1);
    chk("wr_resp_no_write", bus.mem_write, 1'b0);
    @(posedge clk); #1;
    chk("wr_idle", bus.busy, 1'b0);
    op(1'b0, 1'b0, 16'h3, 16'h0);
    wait_idle();
    chk("rd_p0_rdata", bus.p0_rdata, 16'hA5A5);
    op(1'b1, 1'b1, 16'h2, 16'h1111);
    wait_idle();
    grants.delete();
    drive(1'b0, 1'b0, 1'b1, 16'h7, 16'h00FF);
    drive(1'b1, 1'b0, 1'b0, 16'h7, 16'h0);
    run_both(2);
    chk("raw_first", grants[0], 1'b0);
    chk("raw_second", grants[1], 1'b1);
    chk("raw_p1_rdata", bus.p1_rdata, 16'h00FF);
    grants.delete();
    drive(1'b0, 1'b0, 1'b0, 16'h3, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h7, 16'h0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_both(4);
    repeat (3) begin
      bus.p0_req = 1'b1; #1;
      bus.p0_req = 1'b0;
      wait_idle();
    end
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_both(4);
`endif
    for (int i = 0; i < 4; i++) chk("cont_grant", grants[i], exp_g[i]);
    a1 = ack_cnt[1];
    r1 = rsp_cnt[1];
    drive(1'b0, 1'b1, 1'b0, 16'h3, 16'h0);
    #1;
    chk("drop_p0_ack", bus.p0_ack, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h3, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h7, 16'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 16'h7, 16'h0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("drop_p1_acks", ack_cnt[1], a1);
    chk("drop_p1_rsps", rsp_cnt[1], r1);
    s = strobes;
    op(1'b1, 1'b0, 16'h0008, 16'h0);
    wait_idle();
    chk("oor_p1_rdata", bus.p1_rdata, 16'h0);
    op(1'b1, 1'b1, 16'h0010, 16'h1234);
    wait_idle();
    chk("oor_no_strobes", strobes, s);
    chk("oor_p1_rdata_kept", bus.p1_rdata, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 16'h2, 16'hBEEF);
    #1;
    chk("rstw_ack", bus.p0_ack, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h2, 16'hBEEF);
    chk("rstw_mem_write", bus.mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_write_drop", bus.mem_write, 1'b0);
    chk("rstw_busy", bus.busy, 1'b0);
    chk("rstw_p0_rdata", bus.p0_rdata, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstw_mem2", mem[2], 16'h1111);
    op(1'b0, 1'b0, 16'h2, 16'h0);
    wait_idle();
    chk("rstw_readback", bus.p0_rdata, 16'h1111);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the 16-bit, 8-entry data memory. Port 0 is the core load/store stage; port 1 is the DMA/test-loader path. The block serialises accesses, drives the memory's address/write-data/write/read strobes, captures read data and returns a per-port response. It sits between the requesters and the data memory; the memory's read path is combinational and its write is registered on posedge clk.

Parameters:
DATA_W, 16, data word width (must equal memory column width)
ADDR_W, 16, requester/memory address width
DEPTH_LOG2, 3, log2 of memory rows; address bits above this are out of range

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request valid, held until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  port 0 request accepted (1-cycle pulse)
p0_rsp_valid  out  1  port 0 response (1-cycle pulse)
p0_rdata  out  DATA_W  port 0 read data, held until next port 0 response
p0_err  out  1  port 0 response error flag, valid with p0_rsp_valid
p1_*  same set as p0_* for port 1
mem_access_addr  out  ADDR_W  memory address
mem_write_data  out  DATA_W  memory write data
mem_write  out  1  memory write strobe
mem_read  out  1  memory read enable
mem_read_data  in  DATA_W  memory combinational read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, all ack/rsp_valid/err=0, p0_rdata=p1_rdata=0, mem_* outputs=0, last_grant=1 (port 0 wins first contention).
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle occupancy per transaction; back-to-back max 1 op / 3 cycles.
- IDLE: if any pX_req, select winner: one requester -> that port; both -> the port != last_grant (round-robin). Pulse winner's pX_ack this cycle (combinational from state and req), latch we/addr/wdata/owner on posedge, update last_grant, go to ACCESS. Loser gets no ack and must keep its request asserted.
- ACCESS: mem_access_addr=latched addr, mem_write_data=latched wdata. If addr[ADDR_W-1:DEPTH_LOG2] != 0, raise the error flag: mem_write=mem_read=0. Otherwise a write drives mem_write=1 (memory commits at the end of this cycle), and a read drives mem_read=1 and latches mem_read_data into the owner's rdata reg at the end of the cycle. Next state is RESP.
- RESP: owner's pX_rsp_valid=1 for one cycle; pX_err=error flag. An errored read sets rdata to 0. A write leaves rdata unchanged. mem_* outputs are 0. Next state is IDLE.
- mem_write/mem_read are decoded from state, so they are never high outside ACCESS. Reset asserted during ACCESS drops mem_write immediately: no write if reset precedes the clock edge.
- Requests arriving while busy are ignored until IDLE. A request deasserted before ack is dropped with no response.
- Read-after-write by the same or the other port returns the new data (the write commits in ACCESS, before the next ACCESS).

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins contention; last_grant is unused. Port 1 may starve under continuous port 0 traffic; this is intended for boot/debug builds.
- Undefined: round-robin as above.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS of a write of 16'hBEEF to addr 2 -> mem_write falls immediately, busy=0, mem[2] keeps its old value.
- Single write/read: p0 writes 16'hA5A5 to addr 3, then reads addr 3 -> p0_ack in IDLE cycle, mem_write=1 exactly one cycle later, p0_rsp_valid in the third cycle, read returns p0_rdata=16'hA5A5, p0_err=0.
- Contention: p0_req and p1_req both held for 4 transactions -> grant order is p0,p1,p0,p1; with DMEM_ARB_FIXED_PRIO_EN the order is p0,p0,p0,p0.
- Out of range: p1 reads addr 16'h0008, then writes 16'h1234 to addr 16'h0010 -> p1_err=1 for both, p1_rdata=0, mem_write/mem_read never asserted, memory unchanged.
- Cross-port RAW: p0 writes 16'h00FF to addr 7 while p1 reads addr 7 concurrently -> p0 is served first, p1_rdata=16'h00FF.
- Request drop: p1_req pulses one cycle while busy -> no p1_ack, no p1_rsp_valid.
